bht_branch_predictor: RTL
=========================

Name: bht_branch_predictor

Overview:
- Per-PC branch predictor feeding the IF/ID flush and PC-select logic of the 5-stage RISC-V pipeline.
- Holds a table of 2-bit saturating counters indexed by low PC bits.
- Lookup is combinational from the ID-stage branch PC. The counter is updated when the branch resolves in EX.
- Also produces the mispredict indication that drives IF_ID flush and PC redirect.

Parameters:
- ENTRIES, 16, number of counter entries; power of two, minimum 2.
- IDX_W, 4, index width; must equal log2(ENTRIES).
- INIT_STATE, 2'b11, counter value loaded on reset (11 = strongly taken).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous active-low reset; 0 at a rising edge resets the block.
- lookup_valid_i  in  1  ID stage holds a conditional branch.
- lookup_pc_i  in  32  PC of the branch in ID.
- predict_o  out  1  predicted taken (1) or not-taken (0).
- update_valid_i  in  1  EX stage is resolving a branch this cycle.
- update_pc_i  in  32  PC of the resolving branch.
- update_taken_i  in  1  actual outcome (1 = taken).
- update_pred_i  in  1  prediction carried down the pipe with this branch.
- mispredict_o  out  1  resolving branch was mispredicted; flush IF/ID and ID/EX, redirect PC.
- stat_branches_o  out  32  resolved-branch count (only when BHT_STATS_EN is defined).
- stat_mispred_o  out  32  mispredict count (only when BHT_STATS_EN is defined).

Behaviour:
- Index is pc[IDX_W+1:2]. PC bits [1:0] and bits above IDX_W+1 are ignored, so aliasing is allowed.
- predict_o = table[lookup_idx][1] & lookup_valid_i. It is combinational, zero latency, and is 0 whenever lookup_valid_i = 0.
- mispredict_o = update_valid_i & (update_taken_i != update_pred_i). It is combinational and is 0 whenever update_valid_i = 0.
- Update timing: when update_valid_i = 1 at a rising edge, table[update_idx] takes its next state at that edge. When update_valid_i = 0, no entry changes.
- Counter next-state (saturating):
  - 00 -> taken 01, not-taken 00
  - 01 -> taken 10, not-taken 00
  - 10 -> taken 11, not-taken 01
  - 11 -> taken 11, not-taken 10
- Simultaneous lookup and update to the same index: predict_o reflects the pre-update value in that cycle, with no bypass. The new value is visible from the next cycle.
- Only one update is allowed per cycle; there is no port conflict beyond the read/write case above.
- Reset (rst_i = 0 at an edge):
  - every entry is loaded with INIT_STATE;
  - stats are cleared to 0;
  - predict_o follows the combinational rule, so it equals INIT_STATE[1] when lookup_valid_i = 1.
- Reset mid-operation: reset overrides a same-edge update, and the entry is set to INIT_STATE.
- Stalls are handled upstream. The pipeline must not hold update_valid_i high for more than one cycle per branch.

Optional Feature:
- Macro: BHT_STATS_EN.
- With the macro defined:
  - stat_branches_o increments by 1 on each edge with update_valid_i = 1.
  - stat_mispred_o increments by 1 on each edge with mispredict_o = 1.
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, and reset to 0.
- Without the macro: both ports and both counters are absent. All other behaviour is identical.

Decomposition:
- Shared package bp_pkg holds:
  - 2-bit state constants ST_SNT = 00, ST_WNT = 01, ST_WT = 10, ST_ST = 11;
  - the default INIT_STATE;
  - the PC index LSB constant (2).
- One sub-module, sat_counter2: pure next-state function. Inputs are the 2-bit state and the taken bit; output is the 2-bit next state. The top instantiates it once, on the update path.

Test Plan:
- Reset: drive rst_i = 0 for one edge, then lookup_valid_i = 1 at PC 0x00 -> predict_o = 1 (INIT 11), and all stats = 0.
- Saturation down: three not-taken updates at PC 0x08 with update_pred_i = 1, 0, 0 -> entry goes 11 -> 10 -> 01 -> 00. Lookup at 0x08 gives predict_o = 0. mispredict_o = 1 on the first update only.
- Hysteresis: from state 00, taken updates at 0x08 -> predict_o stays 0 after one update and becomes 1 after two (state 10).
- Aliasing: an update at 0x04 and a lookup at 0x44 (ENTRIES = 16) share index 1, so predict_o reflects the update. A lookup at 0x48 (index 2) is unaffected.
- Same-cycle read/write: lookup and not-taken update both at 0x10 from state 10 -> predict_o = 1 in that cycle and 0 in the next.
- Stats (BHT_STATS_EN): 5 updates with 2 mispredicts -> stat_branches_o = 5, stat_mispred_o = 2. Apply rst_i = 0 mid-sequence -> both read 0 on the following cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants for the branch history table: counter encodings,
// default reset state and the PC bit where the table index starts.
package bp_pkg;

  localparam int unsigned CTR_W      = 2;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned STAT_W     = 32;
  localparam int unsigned PC_IDX_LSB = 2;

  localparam logic [CTR_W-1:0] ST_SNT = 2'b00;
  localparam logic [CTR_W-1:0] ST_WNT = 2'b01;
  localparam logic [CTR_W-1:0] ST_WT  = 2'b10;
  localparam logic [CTR_W-1:0] ST_ST  = 2'b11;

  localparam logic [CTR_W-1:0] INIT_STATE_DEF = ST_ST;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [CTR_W-1:0] state_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] next_o
);

  // Step toward strongly taken or strongly not-taken, holding at the ends
  always_comb begin
    next_o = state_i;
    unique case (state_i)
      ST_SNT:  next_o = taken_i ? ST_WNT : ST_SNT;
      ST_WNT:  next_o = taken_i ? ST_WT  : ST_SNT;
      ST_WT:   next_o = taken_i ? ST_ST  : ST_WNT;
      ST_ST:   next_o = taken_i ? ST_ST  : ST_WT;
      default: next_o = state_i;
    endcase
  end

endmodule

// File: rtl/bht_branch_predictor.sv
// Branch history table: 2-bit saturating counters indexed by PC[IDX_W+1:2].
// Combinational lookup from ID, update at the EX resolve edge, plus the
// mispredict flag that drives the IF/ID flush and PC redirect.
// Optional resolved/mispredict statistics counters under BHT_STATS_EN.
module bht_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned       ENTRIES    = 16,
  parameter int unsigned       IDX_W      = 4,
  parameter logic [CTR_W-1:0]  INIT_STATE = INIT_STATE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lookup_valid_i,
  input  logic [PC_W-1:0]   lookup_pc_i,
  output logic              predict_o,
  input  logic              update_valid_i,
  input  logic [PC_W-1:0]   update_pc_i,
  input  logic              update_taken_i,
  input  logic              update_pred_i,
  output logic              mispredict_o
`ifdef BHT_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispred_o
`endif
);

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic [CTR_W-1:0] table_q [ENTRIES];
  logic [CTR_W-1:0] update_cur;
  logic [CTR_W-1:0] entry_d;
  logic             mispredict_c;
  logic             unused_pc_bits;

  assign lookup_idx = lookup_pc_i[PC_IDX_LSB +: IDX_W];
  assign update_idx = update_pc_i[PC_IDX_LSB +: IDX_W];

  // High PC bits and the byte offset only alias into the table
  assign unused_pc_bits = ^{lookup_pc_i[PC_W-1:PC_IDX_LSB+IDX_W],
                            lookup_pc_i[PC_IDX_LSB-1:0],
                            update_pc_i[PC_W-1:PC_IDX_LSB+IDX_W],
                            update_pc_i[PC_IDX_LSB-1:0]};

  // Lookup reads the pre-update value; no write bypass
  assign predict_o    = lookup_valid_i & table_q[lookup_idx][CTR_W-1];
  assign mispredict_c = update_valid_i & (update_taken_i != update_pred_i);
  assign mispredict_o = mispredict_c;

  assign update_cur = table_q[update_idx];

  sat_counter2 u_sat_counter2 (
    .state_i (update_cur),
    .taken_i (update_taken_i),
    .next_o  (entry_d)
  );

  // Counter table: reset wins over a same-edge update
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        table_q[i] <= INIT_STATE;
      end
    end else if (update_valid_i) begin
      table_q[update_idx] <= entry_d;
    end
  end

`ifdef BHT_STATS_EN
  logic [STAT_W-1:0] branches_q;
  logic [STAT_W-1:0] branches_d;
  logic [STAT_W-1:0] mispred_q;
  logic [STAT_W-1:0] mispred_d;

  // Saturating event counters
  always_comb begin
    branches_d = branches_q;
    mispred_d  = mispred_q;
    if (update_valid_i && (branches_q != '1)) begin
      branches_d = branches_q + STAT_W'(1);
    end
    if (mispredict_c && (mispred_q != '1)) begin
      mispred_d = mispred_q + STAT_W'(1);
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else begin
      branches_q <= branches_d;
      mispred_q  <= mispred_d;
    end
  end

  assign stat_branches_o = branches_q;
  assign stat_mispred_o  = mispred_q;
`endif

endmodule
